lcd_bus_ctrl: RTL and testbench

//  Sequences a character-LCD (HD44780-style, 8-bit bus, write-only) from a 9-bit

---
 rtl/lcd_bus_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_lcd_bus_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_ctrl.sv
// lcd_bus_ctrl: write-only HD44780-style 8-bit bus sequencer fed by a
// valid/ready stream of {rs, db[7:0]} words. One shared down-counter times
// power-up, setup, E pulse, hold and command execution wait.
// Optional feature macro: LCD_INIT_SEQ_EN (built-in 0x38/0x0C/0x06/0x01
// init sequence issued after power-up, before the stream is accepted).
module lcd_bus_ctrl #(
   parameter int unsigned CNT_W      = 20,
   parameter int unsigned T_POWERUP  = 750000,
   parameter int unsigned T_SETUP    = 2,
   parameter int unsigned T_EN_HIGH  = 12,
   parameter int unsigned T_HOLD     = 2,
   parameter int unsigned T_CMD_WAIT = 2000,
   parameter int unsigned T_CLR_WAIT = 80000
) (
   input  logic       clock_i,
   input  logic       rstn_i,
   input  logic [8:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       lcd_rs_o,
   output logic       lcd_rw_o,
   output logic       lcd_e_o,
   output logic [7:0] lcd_db_o,
   output logic       busy_o,
   output logic       init_done_o
);

   // Elaboration-time range check: every timing value must fit the counter and be non-zero
   if ((T_POWERUP == 0) || (T_SETUP == 0) || (T_EN_HIGH == 0) || (T_HOLD == 0) ||
       (T_CMD_WAIT == 0) || (T_CLR_WAIT == 0) ||
       ((64'(T_POWERUP)  >> CNT_W) != 64'd0) || ((64'(T_SETUP)    >> CNT_W) != 64'd0) ||
       ((64'(T_EN_HIGH)  >> CNT_W) != 64'd0) || ((64'(T_HOLD)     >> CNT_W) != 64'd0) ||
       ((64'(T_CMD_WAIT) >> CNT_W) != 64'd0) || ((64'(T_CLR_WAIT) >> CNT_W) != 64'd0))
   begin : g_param_err
      $error("lcd_bus_ctrl: timing parameter is zero or does not fit in CNT_W bits");
   end

   // Counter reload values: a state lasting T cycles is loaded with T-1
   localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_POWERUP - 1);
   localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN_HIGH - 1);
   localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD_WAIT - 1);
   localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR_WAIT - 1);

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_WAIT
   } state_t;

   state_t           r_state,     w_state_nxt;
   logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
   logic             r_rs,        w_rs_nxt;
   logic [7:0]       r_db,        w_db_nxt;
   logic             r_e,         w_e_nxt;
   logic             r_ready,     w_ready_nxt;
   logic             r_busy,      w_busy_nxt;
   logic             r_init_done, w_init_done_nxt;
   logic             w_cnt_zero;
   logic             w_is_clear;

`ifdef LCD_INIT_SEQ_EN
   logic [1:0]       r_init_idx,  w_init_idx_nxt;

   // Built-in init command table: function set, display on, entry mode, clear
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    init_cmd = 8'h38;
         2'd1:    init_cmd = 8'h0C;
         2'd2:    init_cmd = 8'h06;
         default: init_cmd = 8'h01;
      endcase
   endfunction
`endif

   assign w_cnt_zero = (r_cnt == '0);
   // Clear display / return home need the long execution wait
   assign w_is_clear = ~r_rs && (r_db[7:2] == 6'd0) && (r_db[1:0] != 2'd0);

   // Next-state, counter, bus and flag logic; outputs derive from the next state
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = w_cnt_zero ? r_cnt : r_cnt - CNT_W'(1);
      w_rs_nxt        = r_rs;
      w_db_nxt        = r_db;
      w_init_done_nxt = r_init_done;
`ifdef LCD_INIT_SEQ_EN
      w_init_idx_nxt  = r_init_idx;
`endif
      case (r_state)
         ST_PWRUP: begin
            if (w_cnt_zero) begin
`ifdef LCD_INIT_SEQ_EN
               // Init commands run through the normal bus phases while init_done is low
               w_state_nxt    = ST_SETUP;
               w_cnt_nxt      = LD_SETUP;
               w_rs_nxt       = 1'b0;
               w_db_nxt       = init_cmd(2'd0);
               w_init_idx_nxt = 2'd0;
`else
               w_state_nxt     = ST_IDLE;
               w_init_done_nxt = 1'b1;
`endif
            end
         end
         ST_IDLE: begin
            if (valid_i && r_ready) begin
               w_state_nxt = ST_SETUP;
               w_cnt_nxt   = LD_SETUP;
               w_rs_nxt    = data_i[8];
               w_db_nxt    = data_i[7:0];
            end
         end
         ST_SETUP: begin
            if (w_cnt_zero) begin
               w_state_nxt = ST_PULSE;
               w_cnt_nxt   = LD_EN;
            end
         end
         ST_PULSE: begin
            if (w_cnt_zero) begin
               w_state_nxt = ST_HOLD;
               w_cnt_nxt   = LD_HOLD;
            end
         end
         ST_HOLD: begin
            if (w_cnt_zero) begin
               w_state_nxt = ST_WAIT;
               w_cnt_nxt   = w_is_clear ? LD_CLR : LD_CMD;
            end
         end
         ST_WAIT: begin
            if (w_cnt_zero) begin
               w_state_nxt = ST_IDLE;
`ifdef LCD_INIT_SEQ_EN
               if (!r_init_done) begin
                  if (r_init_idx == 2'd3) begin
                     w_init_done_nxt = 1'b1;
                  end else begin
                     w_state_nxt    = ST_SETUP;
                     w_cnt_nxt      = LD_SETUP;
                     w_init_idx_nxt = r_init_idx + 2'd1;
                     w_rs_nxt       = 1'b0;
                     w_db_nxt       = init_cmd(r_init_idx + 2'd1);
                  end
               end
`endif
            end
         end
         default: begin
            w_state_nxt = ST_PWRUP;
            w_cnt_nxt   = LD_PWRUP;
         end
      endcase
      w_ready_nxt = (w_state_nxt == ST_IDLE);
      w_busy_nxt  = (w_state_nxt != ST_IDLE);
      w_e_nxt     = (w_state_nxt == ST_PULSE);
   end

   // State, counter and registered outputs; reset drops E immediately
   always_ff @(posedge clock_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state     <= ST_PWRUP;
         r_cnt       <= LD_PWRUP;
         r_rs        <= 1'b0;
         r_db        <= 8'h00;
         r_e         <= 1'b0;
         r_ready     <= 1'b0;
         r_busy      <= 1'b1;
         r_init_done <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
         r_init_idx  <= 2'd0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_rs        <= w_rs_nxt;
         r_db        <= w_db_nxt;
         r_e         <= w_e_nxt;
         r_ready     <= w_ready_nxt;
         r_busy      <= w_busy_nxt;
         r_init_done <= w_init_done_nxt;
`ifdef LCD_INIT_SEQ_EN
         r_init_idx  <= w_init_idx_nxt;
`endif
      end
   end

   assign ready_o     = r_ready;
   assign lcd_rs_o    = r_rs;
   assign lcd_rw_o    = 1'b0;
   assign lcd_e_o     = r_e;
   assign lcd_db_o    = r_db;
   assign busy_o      = r_busy;
   assign init_done_o = r_init_done;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// tb_lcd_bus_ctrl: scoreboard bench for lcd_bus_ctrl with short timing values.
// Accepted words are queued with their accept cycle; each E pulse pops and checks.
module tb_lcd_bus_ctrl;

   localparam int unsigned T_PWR  = 10;
   localparam int unsigned T_SET  = 2;
   localparam int unsigned T_EN   = 4;
   localparam int unsigned T_HLD  = 2;
   localparam int unsigned T_CMD  = 8;
   localparam int unsigned T_CLR  = 20;
   localparam int          XFER   = int'(T_SET + T_EN + T_HLD);
`ifdef LCD_INIT_SEQ_EN
   localparam int          PWR_EXP = int'(T_PWR) + 3 * (XFER + int'(T_CMD)) + XFER + int'(T_CLR);
`else
   localparam int          PWR_EXP = int'(T_PWR);
`endif

   logic       clock_i = 1'b0;
   logic       rstn_i  = 1'b0;
   logic [8:0] data_i  = 9'h000;
   logic       valid_i = 1'b0;
   logic       ready_o, lcd_rs_o, lcd_rw_o, lcd_e_o, busy_o, init_done_o;
   logic [7:0] lcd_db_o;

   int n_checks = 0;
   int n_fail   = 0;

   lcd_bus_ctrl #(
      .CNT_W(20), .T_POWERUP(T_PWR), .T_SETUP(T_SET), .T_EN_HIGH(T_EN),
      .T_HOLD(T_HLD), .T_CMD_WAIT(T_CMD), .T_CLR_WAIT(T_CLR)
   ) u_dut (
      .clock_i(clock_i), .rstn_i(rstn_i), .data_i(data_i), .valid_i(valid_i),
      .ready_o(ready_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o), .lcd_e_o(lcd_e_o),
      .lcd_db_o(lcd_db_o), .busy_o(busy_o), .init_done_o(init_done_o)
   );

   always #5 clock_i = ~clock_i;

   // Single comparison point: counts every check, reports mismatches
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_gap(input logic [8:0] w);
      if (!w[8] && (w[7:2] == 6'd0) && (w[1:0] != 2'd0)) return XFER + int'(T_CLR);
      return XFER + int'(T_CMD);
   endfunction

   // Scoreboard state
   logic [8:0] exp_q[$];
   int         acc_q[$];
   int         cyc = 0, rel_cyc = 0, acc_cyc = 0, gap_exp = 0, rise_cyc = 0, fall_cyc = 0;
   logic       prev_ready = 1'b0, prev_e = 1'b0;
   bit         pend_gap = 0, first_rdy = 1, hold_chk = 0;
   logic [8:0] cur_word = 9'h000;

   // Monitor: samples 1 time unit after each rising edge
   always @(posedge clock_i) begin
      cyc++;
      #1;
      if (!rstn_i) begin
         rel_cyc = cyc;
         exp_q.delete();
         acc_q.delete();
`ifdef LCD_INIT_SEQ_EN
         exp_q.push_back(9'h038); acc_q.push_back(-1);
         exp_q.push_back(9'h00C); acc_q.push_back(-1);
         exp_q.push_back(9'h006); acc_q.push_back(-1);
         exp_q.push_back(9'h001); acc_q.push_back(-1);
`endif
         prev_ready = 1'b0;
         prev_e     = 1'b0;
         pend_gap   = 0;
         first_rdy  = 1;
         hold_chk   = 0;
      end else begin
         if (prev_ready && valid_i) begin
            exp_q.push_back(data_i);
            acc_q.push_back(cyc);
            acc_cyc  = cyc;
            gap_exp  = exp_gap(data_i);
            pend_gap = 1;
            check_eq("ready_drop_after_accept", 32'(ready_o), 32'(1'b0));
         end
         if (ready_o && !prev_ready) begin
            if (first_rdy) begin
               check_eq("pwrup_ready_cycle", cyc - rel_cyc, PWR_EXP);
               check_eq("init_done_at_ready", 32'(init_done_o), 32'(1'b1));
               check_eq("busy_low_at_ready", 32'(busy_o), 32'(1'b0));
               first_rdy = 0;
            end else if (pend_gap) begin
               check_eq("ready_reassert_gap", cyc - acc_cyc, gap_exp);
               pend_gap = 0;
            end
         end
         if (lcd_e_o && !prev_e) begin
            check_eq("sb_word_pending", 32'(exp_q.size() > 0), 32'(1'b1));
            if (exp_q.size() > 0) begin
               cur_word = exp_q.pop_front();
               check_eq("e_rise_word", 32'({lcd_rs_o, lcd_db_o}), 32'(cur_word));
               if (acc_q[0] >= 0) check_eq("setup_cycles", cyc - acc_q[0], int'(T_SET));
               void'(acc_q.pop_front());
            end
            check_eq("rw_low", 32'(lcd_rw_o), 32'(1'b0));
            rise_cyc = cyc;
         end
         if (!lcd_e_o && prev_e) begin
            check_eq("e_high_cycles", cyc - rise_cyc, int'(T_EN));
            check_eq("e_fall_word", 32'({lcd_rs_o, lcd_db_o}), 32'(cur_word));
            fall_cyc = cyc;
            hold_chk = 1;
         end
         if (hold_chk && (cyc - fall_cyc == int'(T_HLD))) begin
            check_eq("hold_end_word", 32'({lcd_rs_o, lcd_db_o}), 32'(cur_word));
            hold_chk = 0;
         end
         prev_ready = ready_o;
         prev_e     = lcd_e_o;
      end
   end

   // Present a word at a falling edge and wait for its accept; optionally keep valid high
   task automatic send(input logic [8:0] w, input bit keep);
      int n;
      n = 0;
      data_i  = w;
      valid_i = 1'b1;
      while (!ready_o && n < 400) begin
         @(negedge clock_i);
         n++;
      end
      if (!ready_o) check_eq("send_timeout", 32'(ready_o), 32'(1'b1));
      @(negedge clock_i);
      if (!keep) valid_i = 1'b0;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!ready_o && n < 400) begin
         @(negedge clock_i);
         n++;
      end
      if (!ready_o) check_eq("wait_ready_timeout", 32'(ready_o), 32'(1'b1));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ready"}, 32'(ready_o), 32'(1'b0));
      check_eq({tag, "_e"}, 32'(lcd_e_o), 32'(1'b0));
      check_eq({tag, "_rs_db"}, 32'({lcd_rs_o, lcd_db_o}), 32'(9'h000));
      check_eq({tag, "_rw"}, 32'(lcd_rw_o), 32'(1'b0));
      check_eq({tag, "_busy"}, 32'(busy_o), 32'(1'b1));
      check_eq({tag, "_init_done"}, 32'(init_done_o), 32'(1'b0));
   endtask

   logic [8:0] stream_w[6];

   initial begin
      int n;
      stream_w = '{9'h148, 9'h165, 9'h06C, 9'h001, 9'h16F, 9'h0C0};

      // Reset state with valid held high
      data_i  = 9'h141;
      valid_i = 1'b1;
      repeat (3) @(negedge clock_i);
      check_reset_outputs("reset");
      rstn_i = 1'b1;

      // Data 'A' accepted as soon as ready rises after power-up
      send(9'h141, 1'b0);
      wait_ready();

      // Clear (long wait) then set DDRAM address (normal wait)
      send(9'h001, 1'b0);
      wait_ready();
      send(9'h080, 1'b0);
      wait_ready();

      // Continuous valid: words consumed in order, one per ready window
      for (int i = 0; i < 6; i++) send(stream_w[i], (i != 5));
      wait_ready();

      // Valid toggling while busy must not capture anything
      send(9'h155, 1'b0);
      data_i = 9'h1FF;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock_i);
         valid_i = ~valid_i;
      end
      valid_i = 1'b0;
      wait_ready();

      // Reset during the E pulse
      send(9'h133, 1'b0);
      n = 0;
      while (!lcd_e_o && n < 50) begin
         @(negedge clock_i);
         n++;
      end
      check_eq("e_seen_before_reset", 32'(lcd_e_o), 32'(1'b1));
      rstn_i = 1'b0;
      #1;
      check_reset_outputs("mid_pulse_reset");
      repeat (2) @(negedge clock_i);
      rstn_i = 1'b1;

      // Full power-up repeats, then a normal write
      send(9'h142, 1'b0);
      wait_ready();
      repeat (3) @(negedge clock_i);
      check_eq("sb_drained", 32'(exp_q.size()), 32'(0));
      check_eq("idle_not_busy", 32'(busy_o), 32'(1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
